branch_cond_resolver: RTL and testbench
=======================================

Name: branch_cond_resolver

Overview:
- Reader side of the 3-bit flag register: consumes the current flag value and the flag write-back bus (`flag_we` / `new_flag`), and resolves conditional branches.
- Tracks in-flight flag-setting instructions. A branch waits until every flag write older than it has landed.
- Produces a registered redirect result (taken, next PC) for the fetch stage.
- Sits in the pipeline between decode (branch issue) and fetch (PC select).

Parameters:
PC_W, 16, width of PC/target buses
MAX_PEND, 3, max in-flight flag-setting instructions tracked

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
flag_issue  in  1  a flag-setting instruction entered the pipeline this cycle
flag_we  in  1  flag register written this cycle (write-back of oldest pending)
new_flag  in  3  value being written, {Z,V,N} = bits [2],[1],[0]
flag  in  3  registered flag value, same bit order
br_valid  in  1  branch request valid
br_ccc  in  3  branch condition code
br_target  in  PC_W  branch target
br_pc_next  in  PC_W  fall-through PC
br_ready  out  1  resolver can accept a branch
res_valid  out  1  one-cycle result strobe
res_taken  out  1  branch taken
res_pc  out  PC_W  br_target if taken, else br_pc_next
stall_issue  out  1  pending counter full; upstream must not assert flag_issue
err  out  1  sticky protocol error

Behaviour:
- Reset (async, rst_n=0): state=IDLE; pend=0; wait_cnt=0; latched branch fields=0; res_valid=0, res_taken=0, res_pc=0, err=0.
  - A reset asserted mid-wait drops the branch; no res_valid is produced.
- Pending counter `pend` (width clog2(MAX_PEND+1)):
  - +1 on flag_issue; -1 on flag_we; both together → unchanged.
  - stall_issue = (pend==MAX_PEND), combinational.
  - flag_issue while full and without flag_we: ignored, err set.
  - flag_we while pend==0 and without flag_issue: ignored, err set.
  - err clears only on reset.
- Effective flag: eff = flag_we ? new_flag : flag (bypass of the same-cycle write).
- Condition on eff:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 & N=0
  - 011 LT: N=1
  - 100 GE: Z=1 | (Z=0 & N=0)
  - 101 LE: N=1 | Z=1
  - 110 OV: V=1
  - 111 unconditional: always taken
- Ordering: a flag_issue in the same cycle as branch acceptance, or later, is younger than the branch and is never waited on.
- FSM:
  - IDLE:
    - br_ready=1.
    - On br_valid: latch ccc, target, pc_next; set wait_cnt = pend.
    - Flags are ready if ccc==111, or pend==0, or (pend==1 & flag_we).
    - Ready → evaluate on eff, register the result, go DONE.
    - Not ready → wait_cnt = pend - flag_we, go WAIT.
  - WAIT:
    - br_ready=0.
    - Each flag_we decrements wait_cnt.
    - When wait_cnt==1 & flag_we: evaluate on eff (bypassed new_flag), go DONE.
    - flag_issue does not affect wait_cnt.
  - DONE:
    - res_valid=1 for exactly this cycle; res_taken and res_pc are held from the evaluation.
    - br_ready=0; next state IDLE.
    - res_taken and res_pc retain their values after the strobe until the next result.
- Latency:
  - Accept with flags ready in cycle T → res_valid in cycle T+1.
  - Waiting branch → res_valid in the cycle after the final older flag_we.
  - Back-to-back branches: minimum one idle cycle between accepts (accepts in cycles T and T+2).
- br_valid while br_ready=0 is ignored; the requester holds it.

Test Plan:
1. Reset, pend=0, flag=3'b100, br_ccc=001, target=16'h0040, pc_next=16'h0012 → next cycle res_valid=1, res_taken=1, res_pc=16'h0040; br_ready=0 that cycle.
2. flag=3'b000, br_ccc=011 (LT) → res_taken=0, res_pc=pc_next. Then br_ccc=110 with flag=3'b010 → res_taken=1.
3. Two flag_issue pulses (pend=2); branch ccc=001 with flag=3'b000 → br_ready=0. flag_we new_flag=3'b000, then flag_we new_flag=3'b100 → res_valid the cycle after the second write, res_taken=1 (bypassed value used).
4. pend=1 with flag_issue and br_valid in the same cycle → wait_cnt=1. A single later flag_we resolves the branch; the second pending write is not waited on; pend ends at 1.
5. Three flag_issue (MAX_PEND) → stall_issue=1. A fourth flag_issue → pend stays 3, err=1. A flag_we at pend=0 after draining → err stays 1.
6. Branch waiting with pend=2, rst_n pulsed low asynchronously mid-cycle → immediately state IDLE, br_ready=1, pend=0, err=0; no res_valid ever asserted for that branch.

Source files
------------

// File: rtl/branch_cond_resolver_if.sv
// ---------------------------------------------------------------------------
// branch_cond_resolver_if
//
// Purpose: bundles every signal exchanged between the pipeline and the
// branch condition resolver, except clock and reset.
//
// Signals (directions given from the resolver's point of view):
//   flag_issue  in   a flag-setting instruction entered the pipeline
//   flag_we     in   flag register written this cycle (oldest pending lands)
//   new_flag    in   value being written, {Z,V,N}
//   flag        in   registered flag value, {Z,V,N}
//   br_valid    in   branch request valid
//   br_ccc      in   branch condition code
//   br_target   in   branch target PC
//   br_pc_next  in   fall-through PC
//   br_ready    out  resolver can accept a branch
//   res_valid   out  one-cycle result strobe
//   res_taken   out  branch taken
//   res_pc      out  redirect PC
//   stall_issue out  pending counter full
//   err         out  sticky protocol error
//
// Modports: master = pipeline side (decode/write-back/fetch), slave = resolver.
// ---------------------------------------------------------------------------
interface branch_cond_resolver_if #(
   parameter int PC_W = 16
);
   logic            flag_issue;
   logic            flag_we;
   logic [2:0]      new_flag;
   logic [2:0]      flag;
   logic            br_valid;
   logic [2:0]      br_ccc;
   logic [PC_W-1:0] br_target;
   logic [PC_W-1:0] br_pc_next;
   logic            br_ready;
   logic            res_valid;
   logic            res_taken;
   logic [PC_W-1:0] res_pc;
   logic            stall_issue;
   logic            err;

   modport master (
      output flag_issue, flag_we, new_flag, flag,
      output br_valid, br_ccc, br_target, br_pc_next,
      input  br_ready, res_valid, res_taken, res_pc, stall_issue, err
   );

   modport slave (
      input  flag_issue, flag_we, new_flag, flag,
      input  br_valid, br_ccc, br_target, br_pc_next,
      output br_ready, res_valid, res_taken, res_pc, stall_issue, err
   );
endinterface

// File: rtl/branch_cond_resolver.sv
// ---------------------------------------------------------------------------
// branch_cond_resolver
//
// Purpose: resolves conditional branches against the 3-bit {Z,V,N} flag
// register. Counts in-flight flag-setting instructions and holds a branch
// until every flag write older than it has landed, then produces a
// registered redirect (taken, next PC) for fetch as a one-cycle strobe.
//
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of branch_cond_resolver_if (flag tracking inputs,
//          branch request, redirect result, stall_issue, err)
//
// Parameters:
//   PC_W      width of PC / target buses
//   MAX_PEND  maximum number of in-flight flag-setting instructions
// ---------------------------------------------------------------------------
module branch_cond_resolver #(
   parameter int PC_W     = 16,
   parameter int MAX_PEND = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   branch_cond_resolver_if.slave  bus
);

   localparam int PW = $clog2(MAX_PEND + 1);
   localparam logic [PW-1:0] PEND_FULL = PW'(MAX_PEND);
   localparam logic [PW-1:0] PEND_ONE  = PW'(1);
   localparam logic [PW-1:0] PEND_ZERO = '0;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [2:0] CC_UNCOND = 3'b111;

   logic [1:0]      r_state;
   logic [PW-1:0]   r_pend;
   logic [PW-1:0]   r_wait_cnt;
   logic [2:0]      r_ccc;
   logic [PC_W-1:0] r_target;
   logic [PC_W-1:0] r_pc_next;
   logic            r_res_taken;
   logic [PC_W-1:0] r_res_pc;
   logic            r_err;

   logic [2:0]      w_eff;
   logic [1:0]      w_state_nxt;
   logic [PW-1:0]   w_wait_nxt;
   logic            w_accept;
   logic            w_eval;
   logic            w_flags_ready;
   logic [2:0]      w_sel_ccc;
   logic [PC_W-1:0] w_sel_target;
   logic [PC_W-1:0] w_sel_pc_next;
   logic            w_taken;
   logic [PC_W-1:0] w_res_pc;

   // Condition table on {Z,V,N}. GE reduces to Z | ~N and LE to N | Z.
   function automatic logic condMet(input logic [2:0] ccc, input logic [2:0] f);
      logic z;
      logic v;
      logic n;
      logic met;
      z = f[2];
      v = f[1];
      n = f[0];
      case (ccc)
         3'b000:  met = ~z;
         3'b001:  met = z;
         3'b010:  met = ~z & ~n;
         3'b011:  met = n;
         3'b100:  met = z | (~z & ~n);
         3'b101:  met = n | z;
         3'b110:  met = v;
         default: met = 1'b1;
      endcase
      return met;
   endfunction

   // A write landing this cycle is bypassed so the branch sees the newest flags
   // one cycle earlier than the flag register would provide them.
   assign w_eff = bus.flag_we ? bus.new_flag : bus.flag;

   // In IDLE the branch fields come straight off the request bus; once waiting
   // they come from the latched copy.
   assign w_sel_ccc     = (r_state == S_IDLE) ? bus.br_ccc     : r_ccc;
   assign w_sel_target  = (r_state == S_IDLE) ? bus.br_target  : r_target;
   assign w_sel_pc_next = (r_state == S_IDLE) ? bus.br_pc_next : r_pc_next;

   assign w_taken  = condMet(w_sel_ccc, w_eff);
   assign w_res_pc = w_taken ? w_sel_target : w_sel_pc_next;

   // Only the writes counted in pend at acceptance are older than the branch;
   // a flag_issue in the accept cycle is younger and never waited on. If the
   // only outstanding write lands in the accept cycle, the bypass covers it.
   assign w_flags_ready = (bus.br_ccc == CC_UNCOND) ||
                          (r_pend == PEND_ZERO) ||
                          ((r_pend == PEND_ONE) && bus.flag_we);

   // Next-state logic for the resolve FSM and the older-writes countdown.
   always_comb begin
      w_state_nxt = r_state;
      w_wait_nxt  = r_wait_cnt;
      w_accept    = 1'b0;
      w_eval      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.br_valid) begin
               w_accept = 1'b1;
               if (w_flags_ready) begin
                  w_eval      = 1'b1;
                  w_wait_nxt  = r_pend;
                  w_state_nxt = S_DONE;
               end else begin
                  w_wait_nxt  = r_pend - PW'(bus.flag_we);
                  w_state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (bus.flag_we) begin
               w_wait_nxt = r_wait_cnt - PEND_ONE;
               if (r_wait_cnt == PEND_ONE) begin
                  w_eval      = 1'b1;
                  w_state_nxt = S_DONE;
               end
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // FSM state, countdown and latched branch fields.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_wait_cnt <= '0;
         r_ccc      <= '0;
         r_target   <= '0;
         r_pc_next  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
         if (w_accept) begin
            r_ccc     <= bus.br_ccc;
            r_target  <= bus.br_target;
            r_pc_next <= bus.br_pc_next;
         end
      end
   end

   // Redirect result registers; they hold the last evaluation between strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res_taken <= 1'b0;
         r_res_pc    <= '0;
      end else if (w_eval) begin
         r_res_taken <= w_taken;
         r_res_pc    <= w_res_pc;
      end
   end

   // Pending flag-write counter with sticky error on overflow/underflow
   // attempts. Issue and write in the same cycle cancel out, even when full
   // or empty, so neither case is an error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend <= '0;
         r_err  <= 1'b0;
      end else begin
         if (bus.flag_issue && !bus.flag_we) begin
            if (r_pend == PEND_FULL) begin
               r_err <= 1'b1;
            end else begin
               r_pend <= r_pend + PEND_ONE;
            end
         end else if (bus.flag_we && !bus.flag_issue) begin
            if (r_pend == PEND_ZERO) begin
               r_err <= 1'b1;
            end else begin
               r_pend <= r_pend - PEND_ONE;
            end
         end
      end
   end

   assign bus.br_ready    = (r_state == S_IDLE);
   assign bus.res_valid   = (r_state == S_DONE);
   assign bus.res_taken   = r_res_taken;
   assign bus.res_pc      = r_res_pc;
   assign bus.stall_issue = (r_pend == PEND_FULL);
   assign bus.err         = r_err;

endmodule

// File: tb/tb_branch_cond_resolver.sv
// ---------------------------------------------------------------------------
// tb_branch_cond_resolver
//
// Purpose: directed testbench for branch_cond_resolver. Expected redirect
// results are pushed into a scoreboard queue when a branch is issued; a
// monitor pops and compares whenever res_valid is seen. Status outputs
// (br_ready, stall_issue, err, strobe timing) are checked inline.
// ---------------------------------------------------------------------------
module tb_branch_cond_resolver;

   localparam int PC_W = 16;

   typedef struct packed {
      logic            taken;
      logic [PC_W-1:0] pc;
   } result_t;

   typedef struct packed {
      logic [2:0] ccc;
      logic [2:0] flg;
      logic       taken;
   } cond_vec_t;

   logic clk;
   logic rst_n;

   int checks;
   int failures;

   result_t expQ[$];

   branch_cond_resolver_if #(.PC_W(PC_W)) bus ();

   branch_cond_resolver #(
      .PC_W     (PC_W),
      .MAX_PEND (3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one value and log a FAIL line on mismatch.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // Drive one cycle's worth of inputs, then let combinational outputs settle.
   task automatic applyStimulus(input logic iss, input logic we,
                                input logic [2:0] nf, input logic [2:0] fl,
                                input logic bv, input logic [2:0] ccc,
                                input logic [PC_W-1:0] tgt,
                                input logic [PC_W-1:0] pcn);
      bus.flag_issue = iss;
      bus.flag_we    = we;
      bus.new_flag   = nf;
      bus.flag       = fl;
      bus.br_valid   = bv;
      bus.br_ccc     = ccc;
      bus.br_target  = tgt;
      bus.br_pc_next = pcn;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pushExp(input logic taken, input logic [PC_W-1:0] pc);
      result_t r;
      r.taken = taken;
      r.pc    = pc;
      expQ.push_back(r);
   endtask

   // Monitor: every result strobe must match the oldest expected result.
   always @(negedge clk) begin
      if (rst_n && bus.res_valid) begin
         if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_result actual=res_valid=1 expected=no strobe");
         end else begin
            result_t e;
            e = expQ.pop_front();
            checkOutput("res_taken", 32'(bus.res_taken), 32'(e.taken));
            checkOutput("res_pc", 32'(bus.res_pc), 32'(e.pc));
         end
      end
   end

   // Watchdog in case the run stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main directed sequence.
   initial begin
      cond_vec_t vecs[15];
      checks   = 0;
      failures = 0;

      // ccc, {Z,V,N}, expected taken -- hand-computed
      vecs[0]  = '{3'b000, 3'b000, 1'b1};
      vecs[1]  = '{3'b000, 3'b100, 1'b0};
      vecs[2]  = '{3'b001, 3'b000, 1'b0};
      vecs[3]  = '{3'b010, 3'b000, 1'b1};
      vecs[4]  = '{3'b010, 3'b001, 1'b0};
      vecs[5]  = '{3'b010, 3'b100, 1'b0};
      vecs[6]  = '{3'b011, 3'b001, 1'b1};
      vecs[7]  = '{3'b100, 3'b001, 1'b0};
      vecs[8]  = '{3'b100, 3'b100, 1'b1};
      vecs[9]  = '{3'b100, 3'b000, 1'b1};
      vecs[10] = '{3'b101, 3'b000, 1'b0};
      vecs[11] = '{3'b101, 3'b001, 1'b1};
      vecs[12] = '{3'b101, 3'b100, 1'b1};
      vecs[13] = '{3'b110, 3'b000, 1'b0};
      vecs[14] = '{3'b111, 3'b000, 1'b1};

      rst_n = 1'b0;
      applyStimulus(0, 0, 3'b000, 3'b000, 0, 3'b000, 16'h0, 16'h0);
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      $display("[TB] reset state");
      checkOutput("rst_br_ready", 32'(bus.br_ready), 32'd1);
      checkOutput("rst_res_valid", 32'(bus.res_valid), 32'd0);
      checkOutput("rst_res_taken", 32'(bus.res_taken), 32'd0);
      checkOutput("rst_res_pc", 32'(bus.res_pc), 32'd0);
      checkOutput("rst_err", 32'(bus.err), 32'd0);
      checkOutput("rst_stall", 32'(bus.stall_issue), 32'd0);
      tick();

      // Flags ready at accept: result strobes the next cycle.
      $display("[TB] EQ with pend=0");
      applyStimulus(0, 0, 3'b000, 3'b100, 1, 3'b001, 16'h0040, 16'h0012);
      pushExp(1'b1, 16'h0040);
      checkOutput("t1_ready_idle", 32'(bus.br_ready), 32'd1);
      tick();
      applyStimulus(0, 0, 3'b000, 3'b100, 0, 3'b000, 16'h0, 16'h0);
      checkOutput("t1_res_valid", 32'(bus.res_valid), 32'd1);
      checkOutput("t1_ready_done", 32'(bus.br_ready), 32'd0);
      tick();
      checkOutput("t1_strobe_end", 32'(bus.res_valid), 32'd0);
      checkOutput("t1_taken_held", 32'(bus.res_taken), 32'd1);
      checkOutput("t1_pc_held", 32'(bus.res_pc), 32'h0040);

      $display("[TB] LT not taken, OV taken");
      applyStimulus(0, 0, 3'b000, 3'b000, 1, 3'b011, 16'h0100, 16'h0022);
      pushExp(1'b0, 16'h0022);
      tick();
      applyStimulus(0, 0, 3'b000, 3'b000, 0, 3'b000, 16'h0, 16'h0);
      checkOutput("t2a_res_valid", 32'(bus.res_valid), 32'd1);
      tick();
      applyStimulus(0, 0, 3'b000, 3'b010, 1, 3'b110, 16'h0200, 16'h0024);
      pushExp(1'b1, 16'h0200);
      tick();
      applyStimulus(0, 0, 3'b000, 3'b010, 0, 3'b000, 16'h0, 16'h0);
      checkOutput("t2b_res_valid", 32'(bus.res_valid), 32'd1);
      tick();

      // Condition table sweep with br_valid held through DONE; a second
      // accept during DONE would produce an unexpected strobe.
      $display("[TB] condition table sweep");
      for (int i = 0; i < 15; i++) begin
         applyStimulus(0, 0, 3'b000, vecs[i].flg, 1, vecs[i].ccc,
                       16'h1000 + 16'(i), 16'h2000 + 16'(i));
         pushExp(vecs[i].taken, vecs[i].taken ? 16'h1000 + 16'(i) : 16'h2000 + 16'(i));
         tick();
         checkOutput("sweep_res_valid", 32'(bus.res_valid), 32'd1);
         checkOutput("sweep_ready_done", 32'(bus.br_ready), 32'd0);
         tick();
      end
      applyStimulus(0, 0, 3'b000, 3'b000, 0, 3'b000, 16'h0, 16'h0);
      tick();

      // Wait on two older writes; the final one is bypassed.
      $display("[TB] wait on two pending writes");
      applyStimulus(1, 0, 3'b000, 3'b000, 0, 3'b000, 16'h0, 16'h0);
      tick();
      tick();
      applyStimulus(0, 0, 3'b000, 3'b000, 1, 3'b001, 16'h0300, 16'h0030);
      pushExp(1'b1, 16'h0300);
      tick();
      applyStimulus(0, 0, 3'b000, 3'b000, 0, 3'b000, 16'h0, 16'h0);
      checkOutput("t3_ready_wait", 32'(bus.br_ready), 32'd0);
      checkOutput("t3_no_valid1", 32'(bus.res_valid), 32'd0);
      applyStimulus(0, 1, 3'b000, 3'b000, 0, 3'b000, 16'h0, 16'h0);
      tick();
      checkOutput("t3_no_valid2", 32'(bus.res_valid), 32'd0);
      checkOutput("t3_ready_wait2", 32'(bus.br_ready), 32'd0);
      applyStimulus(0, 1, 3'b100, 3'b000, 0, 3'b000, 16'h0, 16'h0);
      tick();
      applyStimulus(0, 0, 3'b000, 3'b100, 0, 3'b000, 16'h0, 16'h0);
      checkOutput("t3_res_valid", 32'(bus.res_valid), 32'd1);
      tick();

      // Same-cycle issue is younger than the branch and not waited on.
      $display("[TB] younger issue not waited on");
      applyStimulus(1, 0, 3'b000, 3'b000, 0, 3'b000, 16'h0, 16'h0);
      tick();
      applyStimulus(1, 0, 3'b000, 3'b000, 1, 3'b010, 16'h0400, 16'h0040);
      pushExp(1'b0, 16'h0040);
      tick();
      applyStimulus(0, 1, 3'b001, 3'b000, 0, 3'b000, 16'h0, 16'h0);
      checkOutput("t4_ready_wait", 32'(bus.br_ready), 32'd0);
      tick();
      applyStimulus(0, 0, 3'b000, 3'b001, 0, 3'b000, 16'h0, 16'h0);
      checkOutput("t4_res_valid", 32'(bus.res_valid), 32'd1);
      tick();
      // pend should be 1: two more issues reach the limit.
      applyStimulus(1, 0, 3'b000, 3'b001, 0, 3'b000, 16'h0, 16'h0);
      tick();
      checkOutput("t4_stall_pend2", 32'(bus.stall_issue), 32'd0);
      tick();
      applyStimulus(0, 0, 3'b000, 3'b001, 0, 3'b000, 16'h0, 16'h0);
      checkOutput("t4_stall_pend3", 32'(bus.stall_issue), 32'd1);
      applyStimulus(0, 1, 3'b000, 3'b001, 0, 3'b000, 16'h0, 16'h0);
      tick();
      tick();
      tick();
      applyStimulus(0, 0, 3'b000, 3'b001, 0, 3'b000, 16'h0, 16'h0);
      checkOutput("t4_stall_drained", 32'(bus.stall_issue), 32'd0);
      checkOutput("t4_err_clean", 32'(bus.err), 32'd0);

      // Overflow and underflow attempts set the sticky error.
      $display("[TB] pending limit and err");
      applyStimulus(1, 0, 3'b000, 3'b000, 0, 3'b000, 16'h0, 16'h0);
      tick();
      tick();
      tick();
      checkOutput("t5_stall_full", 32'(bus.stall_issue), 32'd1);
      checkOutput("t5_err_before", 32'(bus.err), 32'd0);
      tick();
      applyStimulus(0, 0, 3'b000, 3'b000, 0, 3'b000, 16'h0, 16'h0);
      checkOutput("t5_err_overflow", 32'(bus.err), 32'd1);
      checkOutput("t5_stall_held", 32'(bus.stall_issue), 32'd1);
      applyStimulus(0, 1, 3'b000, 3'b000, 0, 3'b000, 16'h0, 16'h0);
      tick();
      tick();
      tick();
      checkOutput("t5_stall_drained", 32'(bus.stall_issue), 32'd0);
      tick();
      applyStimulus(0, 0, 3'b000, 3'b000, 0, 3'b000, 16'h0, 16'h0);
      checkOutput("t5_err_sticky", 32'(bus.err), 32'd1);
      checkOutput("t5_no_underflow", 32'(bus.stall_issue), 32'd0);
      tick();

      // Async reset while a branch waits drops it without a strobe.
      $display("[TB] reset mid-wait");
      applyStimulus(1, 0, 3'b000, 3'b000, 0, 3'b000, 16'h0, 16'h0);
      tick();
      tick();
      applyStimulus(0, 0, 3'b000, 3'b000, 1, 3'b001, 16'h0500, 16'h0050);
      tick();
      applyStimulus(0, 0, 3'b000, 3'b000, 0, 3'b000, 16'h0, 16'h0);
      checkOutput("t6_ready_wait", 32'(bus.br_ready), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t6_ready_rst", 32'(bus.br_ready), 32'd1);
      checkOutput("t6_stall_rst", 32'(bus.stall_issue), 32'd0);
      checkOutput("t6_err_rst", 32'(bus.err), 32'd0);
      checkOutput("t6_valid_rst", 32'(bus.res_valid), 32'd0);
      checkOutput("t6_pc_rst", 32'(bus.res_pc), 32'd0);
      tick();
      rst_n = 1'b1;
      #1;
      tick();
      tick();
      tick();
      tick();
      checkOutput("t6_no_valid", 32'(bus.res_valid), 32'd0);
      checkOutput("t6_ready_after", 32'(bus.br_ready), 32'd1);

      checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
